// File: rtl/apb_slave_regfile.sv
// rtl/apb_slave_regfile.sv - APB completer with DEPTH x K register file, optional wait states
// Optional feature macro: APB_SLV_WAIT_EN (fixed WAIT wait states per transfer; zero-wait when undefined)

module apb_slave_regfile #(
    parameter int K     = 8,
    parameter int DEPTH = 12,
    parameter int WAIT  = 2
) (
    input  logic         PCLK,
    input  logic         Preset,
    input  logic         Psel,
    input  logic         Penable,
    input  logic         Pwrite,
    input  logic [3:0]   Paddress,
    input  logic [K-1:0] PWdata,
    output logic [K-1:0] PRdata,
    output logic         Pready,
    output logic         Pslverr
);

    if (DEPTH < 1 || DEPTH > 16 || WAIT < 0 || WAIT > 15) begin : g_param_check
        $error("apb_slave_regfile: DEPTH must be 1..16 and WAIT 0..15");
    end

    typedef enum logic {
        IDLE,
        ACCESS
    } state_t;

    localparam logic [4:0] DEPTH_L = 5'(DEPTH);

    state_t       state_q, state_d;
    logic [3:0]   addr_q, addr_d;
    logic         write_q, write_d;
    logic [K-1:0] wdata_q, wdata_d;
    logic         ready_d, slverr_d;
    logic [K-1:0] rdata_d;
    logic         wr_en;

    logic [3:0]   resp_addr;
    logic         resp_err;
    logic [K-1:0] resp_data;

    logic [K-1:0] regs [DEPTH];

`ifdef APB_SLV_WAIT_EN
    localparam logic [3:0] WAIT_LOAD = 4'(WAIT);
    logic [3:0] cnt_q, cnt_d;
`endif

    // Response lookup: in IDLE the live address is being set up, in ACCESS the latched one is used
    always_comb begin
        resp_addr = (state_q == IDLE) ? Paddress : addr_q;
        resp_err  = ({1'b0, resp_addr} >= DEPTH_L);
        resp_data = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (resp_addr == 4'(i)) begin
                resp_data = regs[i];
            end
        end
        if (resp_err) begin
            resp_data = '0;
        end
    end

    // Next-state and next registered-output logic
    always_comb begin
        state_d  = state_q;
        addr_d   = addr_q;
        write_d  = write_q;
        wdata_d  = wdata_q;
        ready_d  = Pready;
        slverr_d = Pslverr;
        rdata_d  = PRdata;
        wr_en    = 1'b0;
`ifdef APB_SLV_WAIT_EN
        cnt_d    = cnt_q;
`endif
        case (state_q)
            IDLE: begin
                if (Psel && !Penable) begin
                    addr_d  = Paddress;
                    write_d = Pwrite;
                    wdata_d = PWdata;
                    state_d = ACCESS;
`ifdef APB_SLV_WAIT_EN
                    cnt_d = WAIT_LOAD;
                    if (WAIT_LOAD == 4'd0) begin
                        ready_d  = 1'b1;
                        slverr_d = resp_err;
                        rdata_d  = resp_data;
                    end
`else
                    ready_d  = 1'b1;
                    slverr_d = resp_err;
                    rdata_d  = resp_data;
`endif
                end
            end
            ACCESS: begin
                if (!Psel) begin
                    // Master abandoned the transfer: nothing is committed
                    state_d  = IDLE;
                    ready_d  = 1'b0;
                    slverr_d = 1'b0;
                end else if (Penable && Pready) begin
                    wr_en    = write_q && !resp_err;
                    state_d  = IDLE;
                    ready_d  = 1'b0;
                    slverr_d = 1'b0;
                end
`ifdef APB_SLV_WAIT_EN
                else if (!Pready && cnt_q != 4'd0) begin
                    cnt_d = cnt_q - 4'd1;
                    if (cnt_q == 4'd1) begin
                        ready_d  = 1'b1;
                        slverr_d = resp_err;
                        rdata_d  = resp_data;
                    end
                end
`endif
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State, latched setup values and registered outputs
    always_ff @(posedge PCLK) begin
        if (Preset) begin
            state_q <= IDLE;
            addr_q  <= '0;
            write_q <= 1'b0;
            wdata_q <= '0;
            Pready  <= 1'b0;
            Pslverr <= 1'b0;
            PRdata  <= '0;
`ifdef APB_SLV_WAIT_EN
            cnt_q   <= '0;
`endif
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            write_q <= write_d;
            wdata_q <= wdata_d;
            Pready  <= ready_d;
            Pslverr <= slverr_d;
            PRdata  <= rdata_d;
`ifdef APB_SLV_WAIT_EN
            cnt_q   <= cnt_d;
`endif
        end
    end

    // Register file: cleared on reset, written on a successful write completion
    always_ff @(posedge PCLK) begin
        for (int i = 0; i < DEPTH; i++) begin
            if (Preset) begin
                regs[i] <= '0;
            end else if (wr_en && addr_q == 4'(i)) begin
                regs[i] <= wdata_q;
            end
        end
    end

endmodule

// File: tb/tb_apb_slave_regfile.sv
// tb/tb_apb_slave_regfile.sv - directed self-checking bench for apb_slave_regfile

module tb_apb_slave_regfile;

`ifdef APB_SLV_WAIT_EN
    localparam int W = 2;
`else
    localparam int W = 0;
`endif

    logic       PCLK = 1'b0;
    logic       Preset;
    logic       Psel;
    logic       Penable;
    logic       Pwrite;
    logic [3:0] Paddress;
    logic [7:0] PWdata;
    logic [7:0] PRdata;
    logic       Pready;
    logic       Pslverr;

    int tests_run    = 0;
    int tests_failed = 0;
    int pready_hi    = 0;
    int cycle_cnt    = 0;

    logic [7:0] model [16];

    apb_slave_regfile #(.K(8), .DEPTH(12), .WAIT(2)) dut (
        .PCLK     (PCLK),
        .Preset   (Preset),
        .Psel     (Psel),
        .Penable  (Penable),
        .Pwrite   (Pwrite),
        .Paddress (Paddress),
        .PWdata   (PWdata),
        .PRdata   (PRdata),
        .Pready   (Pready),
        .Pslverr  (Pslverr)
    );

    always #5 PCLK = ~PCLK;

    always @(posedge PCLK) cycle_cnt++;

    always @(negedge PCLK) begin
        if (Pready === 1'b1) pready_hi++;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout required completion");
        $fatal(1, "watchdog");
    end

    task automatic idle(input int n);
        Psel    = 1'b0;
        Penable = 1'b0;
        repeat (n) begin
            @(posedge PCLK); #1;
        end
    endtask

    // One full transfer starting now (just after an edge); returns just after the completion edge.
    // During access the address/data/direction lines are scrambled to show they are ignored.
    task automatic xfer(input logic wr, input logic [3:0] a, input logic [7:0] d,
                        output logic [7:0] rd, output logic err, output int cyc);
        Psel     = 1'b1;
        Penable  = 1'b0;
        Pwrite   = wr;
        Paddress = a;
        PWdata   = d;
        cyc      = 1;
        @(posedge PCLK); #1;
        Penable  = 1'b1;
        Pwrite   = ~wr;
        Paddress = a ^ 4'h1;
        PWdata   = ~d;
        cyc      = 2;
        for (int n = 0; n < 40 && Pready !== 1'b1; n++) begin
            @(posedge PCLK); #1;
            cyc++;
        end
        rd  = PRdata;
        err = Pslverr;
        if (Pready !== 1'b1) begin
            tests_run++;
            tests_failed++;
            $display("FAIL xfer_timeout addr=%0h: got Pready=%b required 1", a, Pready);
        end
        @(posedge PCLK); #1;
        Psel    = 1'b0;
        Penable = 1'b0;
    endtask

    task automatic test_reset();
        Preset = 1'b1; Psel = 1'b0; Penable = 1'b0; Pwrite = 1'b0; Paddress = 4'h0; PWdata = 8'h00;
        for (int i = 0; i < 16; i++) model[i] = 8'h00;
        repeat (2) @(posedge PCLK);
        #1;
        tests_run++;
        if (Pready !== 1'b0) begin tests_failed++; $display("FAIL reset_pready: got %b required 0", Pready); end
        tests_run++;
        if (Pslverr !== 1'b0) begin tests_failed++; $display("FAIL reset_pslverr: got %b required 0", Pslverr); end
        tests_run++;
        if (PRdata !== 8'h00) begin tests_failed++; $display("FAIL reset_prdata: got %h required 00", PRdata); end
        Preset = 1'b0;
        idle(1);
    endtask

    task automatic test_write_read();
        logic [7:0] rd; logic err; int cyc;
        xfer(1'b1, 4'd3, 8'hA5, rd, err, cyc);
        model[3] = 8'hA5;
        tests_run++;
        if (cyc !== W + 2) begin tests_failed++; $display("FAIL wr_cycles: got %0d required %0d", cyc, W + 2); end
        tests_run++;
        if (err !== 1'b0) begin tests_failed++; $display("FAIL wr_slverr: got %b required 0", err); end
        tests_run++;
        if (Pready !== 1'b0) begin tests_failed++; $display("FAIL pready_one_cycle: got %b required 0", Pready); end
        xfer(1'b0, 4'd3, 8'h00, rd, err, cyc);
        tests_run++;
        if (rd !== 8'hA5) begin tests_failed++; $display("FAIL rd_addr3: got %h required a5", rd); end
        tests_run++;
        if (err !== 1'b0) begin tests_failed++; $display("FAIL rd_slverr: got %b required 0", err); end
        tests_run++;
        if (cyc !== W + 2) begin tests_failed++; $display("FAIL rd_cycles: got %0d required %0d", cyc, W + 2); end
        xfer(1'b0, 4'd5, 8'h00, rd, err, cyc);
        tests_run++;
        if (rd !== 8'h00) begin tests_failed++; $display("FAIL rd_addr5: got %h required 00", rd); end
        idle(2);
    endtask

    task automatic test_error();
        logic [7:0] rd; logic err; int cyc;
        xfer(1'b1, 4'd14, 8'h3C, rd, err, cyc);
        tests_run++;
        if (err !== 1'b1) begin tests_failed++; $display("FAIL err_wr_slverr: got %b required 1", err); end
        xfer(1'b0, 4'd14, 8'h00, rd, err, cyc);
        tests_run++;
        if (err !== 1'b1) begin tests_failed++; $display("FAIL err_rd_slverr: got %b required 1", err); end
        tests_run++;
        if (rd !== 8'h00) begin tests_failed++; $display("FAIL err_rd_data: got %h required 00", rd); end
        for (int i = 0; i < 12; i++) begin
            xfer(1'b0, 4'(i), 8'h00, rd, err, cyc);
            tests_run++;
            if (rd !== model[i] || err !== 1'b0) begin
                tests_failed++;
                $display("FAIL err_regs_unchanged[%0d]: got %h/%b required %h/0", i, rd, err, model[i]);
            end
        end
        idle(1);
    endtask

    task automatic test_back_to_back();
        logic [7:0] rd0, rd1, rdx; logic err; int cyc; int h; int c0;
        h  = pready_hi;
        c0 = cycle_cnt;
        xfer(1'b1, 4'd0, 8'h11, rdx, err, cyc);
        xfer(1'b1, 4'd1, 8'h22, rdx, err, cyc);
        xfer(1'b0, 4'd0, 8'h00, rd0, err, cyc);
        xfer(1'b0, 4'd1, 8'h00, rd1, err, cyc);
        model[0] = 8'h11;
        model[1] = 8'h22;
        tests_run++;
        if (rd0 !== 8'h11) begin tests_failed++; $display("FAIL b2b_rd0: got %h required 11", rd0); end
        tests_run++;
        if (rd1 !== 8'h22) begin tests_failed++; $display("FAIL b2b_rd1: got %h required 22", rd1); end
        tests_run++;
        if (pready_hi - h !== 4) begin tests_failed++; $display("FAIL b2b_pready_cycles: got %0d required 4", pready_hi - h); end
        tests_run++;
        if (cycle_cnt - c0 !== 4 * (W + 2)) begin
            tests_failed++;
            $display("FAIL b2b_total_cycles: got %0d required %0d", cycle_cnt - c0, 4 * (W + 2));
        end
        idle(1);
    endtask

    task automatic test_abort();
        logic [7:0] rd; logic err; int cyc; int h;
        xfer(1'b1, 4'd2, 8'h5A, rd, err, cyc);
        model[2] = 8'h5A;
        idle(1);
        h = pready_hi;
        Psel = 1'b1; Penable = 1'b0; Pwrite = 1'b1; Paddress = 4'd2; PWdata = 8'hFF;
        @(posedge PCLK); #1;
        Psel = 1'b0; Penable = 1'b0;
        repeat (W + 3) begin
            @(posedge PCLK); #1;
        end
        tests_run++;
        if (pready_hi - h !== ((W == 0) ? 1 : 0)) begin
            tests_failed++;
            $display("FAIL abort_pready_cycles: got %0d required %0d", pready_hi - h, (W == 0) ? 1 : 0);
        end
        tests_run++;
        if (Pready !== 1'b0) begin tests_failed++; $display("FAIL abort_pready_low: got %b required 0", Pready); end
        xfer(1'b0, 4'd2, 8'h00, rd, err, cyc);
        tests_run++;
        if (rd !== 8'h5A) begin tests_failed++; $display("FAIL abort_rd_addr2: got %h required 5a", rd); end
        idle(1);
    endtask

    task automatic test_protocol_violation();
        logic [7:0] rd; logic err; int cyc;
        Psel = 1'b1; Penable = 1'b1; Pwrite = 1'b1; Paddress = 4'd1; PWdata = 8'hEE;
        for (int i = 0; i < 3; i++) begin
            @(posedge PCLK); #1;
            tests_run++;
            if (Pready !== 1'b0) begin tests_failed++; $display("FAIL violation_pready[%0d]: got %b required 0", i, Pready); end
        end
        idle(1);
        xfer(1'b0, 4'd1, 8'h00, rd, err, cyc);
        tests_run++;
        if (rd !== model[1]) begin tests_failed++; $display("FAIL violation_rd_addr1: got %h required %h", rd, model[1]); end
        idle(1);
    endtask

    task automatic test_reset_on_complete();
        logic [7:0] rd; logic err; int cyc;
        Psel = 1'b1; Penable = 1'b0; Pwrite = 1'b1; Paddress = 4'd4; PWdata = 8'h77;
        @(posedge PCLK); #1;
        Penable = 1'b1;
        for (int n = 0; n < 40 && Pready !== 1'b1; n++) begin
            @(posedge PCLK); #1;
        end
        tests_run++;
        if (Pready !== 1'b1) begin tests_failed++; $display("FAIL rstc_reach_ready: got %b required 1", Pready); end
        Preset = 1'b1;
        @(posedge PCLK); #1;
        Preset = 1'b0; Psel = 1'b0; Penable = 1'b0;
        for (int i = 0; i < 16; i++) model[i] = 8'h00;
        tests_run++;
        if (Pready !== 1'b0 || Pslverr !== 1'b0 || PRdata !== 8'h00) begin
            tests_failed++;
            $display("FAIL rstc_outputs: got %b/%b/%h required 0/0/00", Pready, Pslverr, PRdata);
        end
        idle(1);
        xfer(1'b0, 4'd4, 8'h00, rd, err, cyc);
        tests_run++;
        if (rd !== 8'h00) begin tests_failed++; $display("FAIL rstc_rd_addr4: got %h required 00", rd); end
        xfer(1'b0, 4'd0, 8'h00, rd, err, cyc);
        tests_run++;
        if (rd !== model[0]) begin tests_failed++; $display("FAIL rstc_rd_addr0: got %h required %h", rd, model[0]); end
        idle(1);
    endtask

    initial begin
        test_reset();
        test_write_read();
        test_error();
        test_back_to_back();
        test_abort();
        test_protocol_violation();
        test_reset_on_complete();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
